rx_crc: RTL
===========

# rx_crc

Receive-side CRC checker, the counterpart of the transmit-side CRC generator. It accepts a received word of DATA_LENGTH data bits with CRC_LENGTH appended check bits. It runs the same bit-serial modulo-2 division over the whole codeword, one data bit per clock, and reports pass/fail with a one-cycle valid pulse. It also keeps the recovered data, the syndrome and a saturating error count for link monitoring.

## Interface
- DATA_LENGTH, 32, payload bits per codeword (≥ 2)
- CRC_LENGTH, 8, check bits per codeword
- CRC_POLY, 8'h07, generator polynomial without the implicit x^CRC_LENGTH term (CRC_LENGTH bits)
- CNT_WIDTH, 6, bit-counter width; must satisfy 2^CNT_WIDTH > DATA_LENGTH
- ERR_CNT_WIDTH, 16, error-counter width
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous assert, active-low
- rx_crc_i  input  DATA_LENGTH+CRC_LENGTH  received codeword {data, crc}, sampled only on rx_crc_start
- rx_crc_start  input  1  single-cycle load/start pulse
- rx_crc_err_clr  input  1  synchronous clear of rx_crc_err_cnt
- rx_crc_busy  output  1  division in progress
- rx_crc_vld  output  1  one-cycle result strobe
- rx_crc_err  output  1  1 = nonzero syndrome; valid from rx_crc_vld, held until next start
- rx_crc_syndrome  output  CRC_LENGTH  final remainder; 0 = pass
- rx_crc_data  output  DATA_LENGTH  data field of the last loaded codeword
- rx_crc_cnt  output  CNT_WIDTH  bit counter
- rx_crc_err_cnt  output  ERR_CNT_WIDTH  saturating count of failed codewords

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE. All outputs reset to 0.
- rx_crc_start in any state:
  - load the shift register with rx_crc_i (CRC_LENGTH+DATA_LENGTH bits);
  - capture the data field into rx_crc_data;
  - clear rx_crc_cnt and rx_crc_err;
  - go to CALC.
- Start in CALC aborts the current word and restarts. No result is produced for the aborted word.
- CALC, each cycle:
  - top CRC_LENGTH bits <= (MSB ? next-lower CRC_LENGTH bits ^ CRC_POLY : next-lower CRC_LENGTH bits);
  - lower DATA_LENGTH bits shift left with 0 fill;
  - rx_crc_cnt increments.
- In CALC with rx_crc_cnt == DATA_LENGTH-1, the step above still executes, then the block goes to DONE and pulses rx_crc_vld.
- DONE:
  - rx_crc_syndrome = top CRC_LENGTH bits of the shift register (combinational from the register);
  - rx_crc_err = |syndrome, registered at the transition into DONE;
  - the block stays in DONE, holding everything, until the next start.
- Syndrome identity: syndrome = received CRC ^ CRC computed over the data field. A codeword from the TX generator with the same parameters gives syndrome 0.
- rx_crc_busy = 1 exactly in CALC.
- rx_crc_err_cnt increments by 1 in the cycle rx_crc_vld is asserted with rx_crc_err = 1. It saturates at all-ones.
- rx_crc_err_clr has priority over the increment and zeroes the counter next edge.
- rx_crc_cnt holds its value outside CALC and never wraps: CALC exits at DATA_LENGTH-1.
- rx_crc_syndrome is don't-care outside DONE. The bench checks it only when rx_crc_vld or DONE.

## Timing
- Start sampled at edge E0. CALC shifts occur at edges E1..E_DATA_LENGTH (rx_crc_cnt 0..DATA_LENGTH-1 before each).
- rx_crc_vld is high for exactly the cycle after edge E_DATA_LENGTH, i.e. DATA_LENGTH cycles after the start edge (32 at defaults).
- rx_crc_err and rx_crc_syndrome are valid in that same cycle.
- Back-to-back: a start in the rx_crc_vld cycle is legal. The vld pulse is still seen, and the new word begins.
- Start and rx_crc_vld generation at the same edge: start wins, and no vld pulse occurs.
- rst_n low mid-CALC: immediate return to IDLE, all outputs 0, and no vld after release.
- Throughput: one codeword per DATA_LENGTH+1 cycles maximum.

## Test plan
- Clean word: rx_crc_i = {32'h00000001, 8'h07} -> vld 32 cycles after start, err=0, syndrome=8'h00, data=32'h00000001, err_cnt unchanged.
- Corrupt word: {32'h00000100, 8'h14} (correct CRC is 8'h15) -> err=1, syndrome=8'h01, err_cnt increments by 1.
- Abort/restart: start with a corrupt word, then a new start at cnt=10 with {32'h0, 8'h00} -> single vld 32 cycles after the second start, err=0, err_cnt unchanged.
- Back-to-back: three words with starts in each vld cycle (clean, bad, clean) -> three vld pulses 33 cycles apart, err pattern 0,1,0, err_cnt +1.
- Counter saturation and clear:
  - preset near max (ERR_CNT_WIDTH reduced or forced) and send bad words -> err_cnt sticks at all-ones;
  - assert clr in the same cycle as a failing vld -> err_cnt = 0.
- Reset mid-operation: assert rst_n low at cnt=5 -> all outputs 0 immediately, busy=0, no vld in the following 40 cycles.

Source files
------------

// File: rtl/rx_crc_if.sv
// Bus bundle for the receive-side CRC checker: codeword/start/clear in,
// status, result and monitoring counters out.
interface rx_crc_if #(
  parameter int unsigned DATA_LENGTH   = 32,
  parameter int unsigned CRC_LENGTH    = 8,
  parameter int unsigned CNT_WIDTH     = 6,
  parameter int unsigned ERR_CNT_WIDTH = 16
) ();

  logic [DATA_LENGTH+CRC_LENGTH-1:0] rx_crc_i;
  logic                              rx_crc_start;
  logic                              rx_crc_err_clr;
  logic                              rx_crc_busy;
  logic                              rx_crc_vld;
  logic                              rx_crc_err;
  logic [CRC_LENGTH-1:0]             rx_crc_syndrome;
  logic [DATA_LENGTH-1:0]            rx_crc_data;
  logic [CNT_WIDTH-1:0]              rx_crc_cnt;
  logic [ERR_CNT_WIDTH-1:0]          rx_crc_err_cnt;

  // Driver side (source of codewords)
  modport master (
    output rx_crc_i,
    output rx_crc_start,
    output rx_crc_err_clr,
    input  rx_crc_busy,
    input  rx_crc_vld,
    input  rx_crc_err,
    input  rx_crc_syndrome,
    input  rx_crc_data,
    input  rx_crc_cnt,
    input  rx_crc_err_cnt
  );

  // Checker side
  modport slave (
    input  rx_crc_i,
    input  rx_crc_start,
    input  rx_crc_err_clr,
    output rx_crc_busy,
    output rx_crc_vld,
    output rx_crc_err,
    output rx_crc_syndrome,
    output rx_crc_data,
    output rx_crc_cnt,
    output rx_crc_err_cnt
  );

endinterface

// File: rtl/rx_crc.sv
// Receive-side CRC checker. Divides the whole {data, crc} codeword bit-serially
// by the generator polynomial, one data bit per clock; a zero remainder means
// the codeword is intact. Keeps the recovered data, the syndrome and a
// saturating count of failed codewords.
module rx_crc #(
  parameter int unsigned            DATA_LENGTH   = 32,
  parameter int unsigned            CRC_LENGTH    = 8,
  parameter logic [CRC_LENGTH-1:0]  CRC_POLY      = 'h07,
  parameter int unsigned            CNT_WIDTH     = 6,
  parameter int unsigned            ERR_CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  rx_crc_if.slave  bus
);

  localparam int unsigned W = DATA_LENGTH + CRC_LENGTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_LENGTH - 1);

  logic [1:0]               state_q, state_d;
  logic [W-1:0]             sr_q, sr_d;
  logic [DATA_LENGTH-1:0]   data_q, data_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     vld_q, vld_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [W-1:0]             sr_step;
  logic [CRC_LENGTH-1:0]    rem_step;

  // One division step: fold the polynomial into the remainder window when the
  // leading bit is set, while the data bits march up underneath it.
  always_comb begin
    rem_step = sr_q[W-1] ? (sr_q[W-2 -: CRC_LENGTH] ^ CRC_POLY)
                         : sr_q[W-2 -: CRC_LENGTH];
    sr_step  = {rem_step, sr_q[DATA_LENGTH-2:0], 1'b0};
  end

  // Control and datapath next-state; a start always wins, even over the vld
  // that would otherwise be produced on the same edge.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    if (bus.rx_crc_start) begin
      sr_d    = bus.rx_crc_i;
      data_d  = bus.rx_crc_i[W-1 -: DATA_LENGTH];
      cnt_d   = '0;
      err_d   = 1'b0;
      state_d = S_CALC;
    end else begin
      case (state_q)
        S_CALC: begin
          sr_d  = sr_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            vld_d   = 1'b1;
            err_d   = |rem_step;
          end
        end
        S_DONE:  state_d = S_DONE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Failed-codeword counter: clear beats increment, increment stops at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.rx_crc_err_clr) begin
      err_cnt_d = '0;
    end else if (vld_q && err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.rx_crc_busy     = (state_q == S_CALC);
  assign bus.rx_crc_vld      = vld_q;
  assign bus.rx_crc_err      = err_q;
  assign bus.rx_crc_syndrome = (state_q == S_DONE) ? sr_q[W-1 -: CRC_LENGTH] : '0;
  assign bus.rx_crc_data     = data_q;
  assign bus.rx_crc_cnt      = cnt_q;
  assign bus.rx_crc_err_cnt  = err_cnt_q;

endmodule
